// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter with a 4-deep byte FIFO and a pollable status register.
// Optional even parity bit (8E1 framing) is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_mmio #(
    parameter logic [31:0] DATA_ADDR    = 32'd1028,
    parameter logic [31:0] STATUS_ADDR  = 32'd1032,
    parameter int          CLKS_PER_BIT = 234
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] data_out,
    input  logic        mem_en,
    input  logic        mem_read,
    output logic [31:0] data_in,
    output logic        tx
);

    localparam int            TW         = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_e;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          wr_prev_q, rd_prev_q;
    logic          ovf_q, ovf_d;
    logic [7:0]    fifo_mem_q [4];
    logic [1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [2:0]    count_q, count_d;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic wr_s, rd_s, wr_rise_s, rd_rise_s;
    logic empty_s, full_s, busy_s, pop_s, push_ok_s, drop_s;
    logic unused_s;

    assign wr_s      = mem_en && !mem_read && (addr == DATA_ADDR);
    assign rd_s      = mem_en &&  mem_read && (addr == STATUS_ADDR);
    assign wr_rise_s = wr_s && !wr_prev_q;
    assign rd_rise_s = rd_s && !rd_prev_q;
    assign empty_s   = (count_q == 3'd0);
    assign full_s    = (count_q == 3'd4);
    assign busy_s    = (state_q != ST_IDLE);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok_s = wr_rise_s && (!full_s || pop_s);
    assign drop_s    = wr_rise_s && full_s && !pop_s;
    assign unused_s  = ^data_out[31:8];
    assign tx        = tx_q;

    // Status read mux: only visible while the status strobe is active.
    always_comb begin
        data_in = 32'd0;
        if (rd_s) begin
            data_in = {28'd0, ovf_q, busy_s, full_s, empty_s};
        end else begin
            data_in = 32'd0;
        end
    end

    // FIFO pointer/count and sticky overflow next-state.
    always_comb begin
        wptr_d  = push_ok_s ? wptr_q + 2'd1 : wptr_q;
        rptr_d  = pop_s ? rptr_q + 2'd1 : rptr_q;
        count_d = count_q + {2'd0, push_ok_s} - {2'd0, pop_s};
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (rd_rise_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Transmit FSM next-state; tx_d is the line level for the next state.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s    = 1'b1;
                    shift_d  = fifo_mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_mem_q[rptr_q]);
`endif
                    timer_d  = TIMER_LOAD;
                    bit_d    = 3'd0;
                    state_d  = ST_START;
                    tx_d     = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end
            ST_START: begin
                if (timer_q == '0) begin
                    timer_d = TIMER_LOAD;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (timer_q == '0) begin
                    timer_d = TIMER_LOAD;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (timer_q == '0) begin
                    timer_d = TIMER_LOAD;
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // FSM, FIFO bookkeeping and strobe-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            wr_prev_q <= 1'b0;
            rd_prev_q <= 1'b0;
            ovf_q     <= 1'b0;
            wptr_q    <= 2'd0;
            rptr_q    <= 2'd0;
            count_q   <= 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_prev_q <= wr_s;
            rd_prev_q <= rd_s;
            ovf_q     <= ovf_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_q[i] <= 8'd0;
            end
        end else if (push_ok_s) begin
            fifo_mem_q[wptr_q] <= data_out[7:0];
        end else begin
            fifo_mem_q <= fifo_mem_q;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio (CLKS_PER_BIT=4): a serial monitor decodes
// frames on tx and compares them against a queue of bytes expected on the line.
module tb_uart_tx_mmio;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * C;
`else
    localparam int FRAME = 10 * C;
`endif
    localparam logic [31:0] DADDR = 32'd1028;
    localparam logic [31:0] SADDR = 32'd1032;

    logic        clk, rst_n;
    logic [31:0] addr, data_out, data_in;
    logic        mem_en, mem_read, tx;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          frames_done = 0;
    bit          mon_en   = 1'b1;
    logic [7:0]  sb[$];
    int          starts[$];

    uart_tx_mmio #(.DATA_ADDR(DADDR), .STATUS_ADDR(SADDR), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data_out(data_out),
        .mem_en(mem_en), .mem_read(mem_read), .data_in(data_in), .tx(tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Serial monitor: samples bit centres and compares against the scoreboard.
    initial begin
        logic [7:0] got, exp;
        int st;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                st = cyc;
                starts.push_back(st);
                repeat (C / 2) @(negedge clk);
                n_checks++;
                if (tx !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_bit: got %b expected 0 (frame at cycle %0d)", tx, st);
                end
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    got[i] = tx;
                end
                exp = 8'h00;
                if (sb.size() > 0) exp = sb.pop_front();
                else begin
                    n_fail++;
                    $display("FAIL unexpected_frame: got byte %h expected no frame", got);
                end
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL frame_data: got %h expected %h", got, exp);
                end
`ifdef UART_TX_PARITY_EN
                repeat (C) @(negedge clk);
                n_checks++;
                if (tx !== ^exp) begin
                    n_fail++;
                    $display("FAIL parity_bit: got %b expected %b for byte %h", tx, ^exp, exp);
                end
`endif
                repeat (C) @(negedge clk);
                n_checks++;
                if (tx !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stop_bit: got %b expected 1", tx);
                end
                frames_done++;
            end
        end
    end

    task automatic write_byte(input logic [7:0] b, input int hold);
        mem_en = 1'b1; mem_read = 1'b0; addr = DADDR; data_out = {24'hABCDEF, b};
        repeat (hold) @(negedge clk);
        mem_en = 1'b0; addr = 32'd0; data_out = 32'd0;
    endtask

    task automatic read_status(output logic [31:0] v);
        mem_en = 1'b1; mem_read = 1'b1; addr = SADDR;
        #1 v = data_in;
        @(negedge clk);
        mem_en = 1'b0; mem_read = 1'b0; addr = 32'd0;
    endtask

    task automatic check_status(input string name, input logic [31:0] exp);
        logic [31:0] v;
        read_status(v);
        n_checks++;
        if (v !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, v, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_frames(input string name, input int target, input int budget);
        int k = 0;
        while (frames_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (frames_done < target) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d frames expected %0d", name, frames_done, target);
        end
    endtask

    task automatic wait_start(input int n0, output int s);
        for (int k = 0; k < 20 && starts.size() == n0; k++) @(negedge clk);
        n_checks++;
        if (starts.size() == n0) begin
            n_fail++;
            $display("FAIL start_timeout: got no start bit expected one");
            s = cyc;
        end else begin
            s = starts[n0];
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1; mem_en = 1'b0; mem_read = 1'b0; addr = 32'd0; data_out = 32'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
        n_checks++;
        if (data_in !== 32'd0) begin n_fail++; $display("FAIL reset_data_in: got %h expected 0", data_in); end
        check_status("reset_status", 32'h1);
    endtask

    task automatic test_single;
        int p, s, n0;
        n0 = starts.size();
        sb.push_back(8'hA5);
        write_byte(8'hA5, 1);
        p = cyc;
        wait_start(n0, s);
        n_checks++;
        if (s != p + 1) begin n_fail++; $display("FAIL start_latency: got cycle %0d expected %0d", s, p + 1); end
        wait_cyc(s + FRAME - 1);
        check_status("single_busy", 32'h5);
        check_status("single_idle", 32'h1);
        wait_frames("single", n0 + 1, 20);
    endtask

    task automatic test_held;
        int n0;
        n0 = frames_done;
        sb.push_back(8'h3C);
        write_byte(8'h3C, 50);
        repeat (FRAME + 20) @(negedge clk);
        n_checks++;
        if (frames_done != n0 + 1) begin n_fail++; $display("FAIL held_frames: got %0d expected %0d", frames_done - n0, 1); end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL held_pending: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_overflow;
        int n0, i0;
        n0 = frames_done; i0 = starts.size();
        for (int b = 1; b <= 6; b++) begin
            if (b <= 5) sb.push_back(8'(b));
            write_byte(8'(b), 1);
            @(negedge clk);
        end
        check_status("ovf_status", 32'hE);
        @(negedge clk);
        check_status("ovf_cleared", 32'h6);
        wait_frames("ovf", n0 + 5, 5 * (FRAME + 1) + 40);
        for (int k = 1; k < 5; k++) begin
            n_checks++;
            if (starts[i0 + k] - starts[i0 + k - 1] != FRAME + 1) begin
                n_fail++;
                $display("FAIL ovf_gap%0d: got %0d expected %0d", k, starts[i0 + k] - starts[i0 + k - 1], FRAME + 1);
            end
        end
    endtask

    task automatic test_simul;
        int n0, i0, s;
        logic [7:0] bytes [5];
        n0 = frames_done; i0 = starts.size();
        bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        for (int k = 0; k < 5; k++) begin
            sb.push_back(bytes[k]);
            write_byte(bytes[k], 1);
            @(negedge clk);
        end
        wait_start(i0, s);
        wait_cyc(s + FRAME);
        sb.push_back(8'hF6);
        write_byte(8'hF6, 1);
        check_status("simul_status", 32'h6);
        wait_frames("simul", n0 + 6, 6 * (FRAME + 1) + 40);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL simul_pending: got %0d expected 0", sb.size()); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        int n0;
        n0 = frames_done;
        sb.push_back(8'h07);
        write_byte(8'h07, 1);
        @(negedge clk);
        sb.push_back(8'h03);
        write_byte(8'h03, 1);
        wait_frames("parity", n0 + 2, 2 * (FRAME + 1) + 30);
    endtask
`endif

    task automatic test_reset_midframe;
        int high_ok;
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        write_byte(8'h55, 1);
        @(negedge clk);
        write_byte(8'hAA, 1);
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_low: got %b expected 0", tx); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL midframe_reset_tx: got %b expected 1", tx); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        high_ok = 1;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) high_ok = 0;
        end
        n_checks++;
        if (high_ok != 1) begin n_fail++; $display("FAIL midframe_discard: got tx activity expected idle line"); end
        check_status("midframe_status", 32'h1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_held();
        test_overflow();
        test_simul();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
